// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the memory port arbiter: access sizes,
// FSM states, grant owner and the default abort limit.
package dlx_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_IBUSY = 2'b01,
    S_DBUSY = 2'b10,
    S_DERR  = 2'b11
  } state_e;

  typedef enum logic {
    G_IF = 1'b0,
    G_D  = 1'b1
  } grant_e;

  // Reserved size 10 is handled like a word.
  function automatic logic aligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic ok;
    unique case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lo[0];
      default: ok = (lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extension.
// rdata: raw memory word; size: access size; sign: 1 = sign-extend; data: result.
module load_extend
  import dlx_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  always_comb begin
    data = rdata;
    unique case (size)
      SZ_BYTE: data = {{24{sign & rdata[7]}}, rdata[7:0]};
      SZ_HALF: data = {{16{sign & rdata[15]}}, rdata[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one memory port.
// Ports: fetch (if_*), data (d_*), memory (mem_*), pipeline stall.
module mem_port_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall
);

  // The count reaches TIMEOUT on the edge that aborts, so mem_req
  // is held for exactly TIMEOUT cycles when no ack arrives.
  localparam logic [3:0] TMO_M1 = 4'(TIMEOUT - 1);

  state_e      state, state_nx;
  grant_e      lg, lg_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        sign_q, sign_nx;

  logic        mem_req_nx, mem_wr_nx;
  logic [1:0]  mem_size_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic [31:0] if_rdata_nx, d_rdata_nx;
  logic        if_done_nx, d_done_nx, d_err_nx;

  logic        idle_ok, pick_d, pick_i, d_ok, tmo;
  logic [31:0] ext;

  load_extend u_ext (
    .rdata (mem_rdata),
    .size  (mem_size),
    .sign  (sign_q),
    .data  (ext)
  );

  // No grant in the done cycle: the finishing requester still
  // holds its request for that one cycle.
  assign idle_ok = (state == S_IDLE) & ~if_done & ~d_done;
  assign pick_d  = idle_ok & d_req & (~if_req | (lg == G_IF));
  assign pick_i  = idle_ok & if_req & ~pick_d;
  assign d_ok    = aligned(d_size, d_addr[1:0]);
  assign tmo     = (cnt == TMO_M1);

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  always_comb begin
    state_nx     = state;
    lg_nx        = lg;
    cnt_nx       = cnt;
    sign_nx      = sign_q;
    mem_req_nx   = mem_req;
    mem_wr_nx    = mem_wr;
    mem_size_nx  = mem_size;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    d_rdata_nx   = d_rdata;
    if_done_nx   = 1'b0;
    d_done_nx    = 1'b0;
    d_err_nx     = 1'b0;

    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          pick_d: begin
            lg_nx = G_D;
            if (d_ok) begin
              state_nx     = S_DBUSY;
              cnt_nx       = 4'd0;
              sign_nx      = d_sign;
              mem_req_nx   = 1'b1;
              mem_wr_nx    = d_wr;
              mem_size_nx  = d_size;
              mem_addr_nx  = d_addr;
              mem_wdata_nx = d_wdata;
            end else begin
              state_nx   = S_DERR;
              d_done_nx  = 1'b1;
              d_err_nx   = 1'b1;
              d_rdata_nx = 32'd0;
            end
          end
          pick_i: begin
            lg_nx        = G_IF;
            state_nx     = S_IBUSY;
            cnt_nx       = 4'd0;
            mem_req_nx   = 1'b1;
            mem_wr_nx    = 1'b0;
            mem_size_nx  = SZ_WORD;
            mem_addr_nx  = if_addr;
            mem_wdata_nx = 32'd0;
          end
          default: ;
        endcase
      end
      S_IBUSY: begin
        if (mem_ack) begin
          state_nx    = S_IDLE;
          mem_req_nx  = 1'b0;
          if_done_nx  = 1'b1;
          if_rdata_nx = mem_rdata;
        end else begin
          cnt_nx = cnt + 4'd1;
          if (tmo) begin
            state_nx    = S_IDLE;
            mem_req_nx  = 1'b0;
            if_done_nx  = 1'b1;
            if_rdata_nx = 32'd0;
          end
        end
      end
      S_DBUSY: begin
        if (mem_ack) begin
          state_nx   = S_IDLE;
          mem_req_nx = 1'b0;
          d_done_nx  = 1'b1;
          d_rdata_nx = mem_wr ? 32'd0 : ext;
        end else begin
          cnt_nx = cnt + 4'd1;
          if (tmo) begin
            state_nx   = S_IDLE;
            mem_req_nx = 1'b0;
            d_done_nx  = 1'b1;
            d_err_nx   = 1'b1;
            d_rdata_nx = 32'd0;
          end
        end
      end
      S_DERR: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lg        <= G_IF;
      cnt       <= 4'd0;
      sign_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'b00;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      state     <= state_nx;
      lg        <= lg_nx;
      cnt       <= cnt_nx;
      sign_q    <= sign_nx;
      mem_req   <= mem_req_nx;
      mem_wr    <= mem_wr_nx;
      mem_size  <= mem_size_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      d_rdata   <= d_rdata_nx;
      if_done   <= if_done_nx;
      d_done    <= d_done_nx;
      d_err     <= d_err_nx;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles in a busy state before an access is aborted.
REQ-002 SHALL have ports, in this order:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  32  fetch word address.
- if_rdata  out  32  fetched instruction, registered.
- if_done  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, level, held until d_done.
- d_wr  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 11 word; 10 reserved, treated as word.
- d_sign  in  1  1 = sign-extend load, 0 = zero-extend.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  extended load data, registered.
- d_done  out  1  one-cycle data completion pulse.
- d_err  out  1  qualifies d_done: misaligned or timed out.
- mem_req  out  1  memory access strobe, held until mem_ack.
- mem_wr  out  1  memory write enable.
- mem_size  out  2  memory access size.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid when mem_ack = 1.
- mem_ack  in  1  memory completion, sampled on clk.
- stall  out  1  pipeline stall request.

Function
REQ-003 SHALL implement an FSM with states IDLE, IBUSY, DBUSY and DERR.
REQ-004 IDLE, only if_req: SHALL go to IBUSY; mem_req=1, mem_wr=0, mem_size=11, mem_addr=if_addr from the next cycle.
REQ-005 IDLE, only d_req, aligned: SHALL go to DBUSY; mem_* driven from the d_* inputs from the next cycle.
REQ-006 IDLE, both requests pending: SHALL grant the requester not granted last (last_grant flag); after reset last_grant = IF, so data wins first.
REQ-007 Aligned means: size 01 requires addr[0]=0; size 11/10 requires addr[1:0]=00. A misaligned data grant SHALL go to DERR with no mem_req.
REQ-008 DERR SHALL last one cycle: d_done=1, d_err=1, d_rdata=0, then return to IDLE; it SHALL update last_grant.
REQ-009 mem_req and all mem_* outputs SHALL be registered and stable from issue until the cycle mem_ack is sampled high; ack is allowed in the first busy cycle.
REQ-010 On mem_ack in IBUSY: the next cycle SHALL have if_done=1 and if_rdata=mem_rdata; mem_req=0; state returns to IDLE.
REQ-011 On mem_ack in DBUSY: the next cycle SHALL have d_done=1, d_err=0, and d_rdata as follows:
- store: 0.
- byte: mem_rdata[7:0] extended per d_sign.
- half: mem_rdata[15:0] extended per d_sign.
- word: mem_rdata.
REQ-012 Fastest access SHALL be: request at cycle N, mem_req at N+1, ack at N+1, done at N+2; the next grant is no earlier than the cycle after done.
REQ-013 A 4-bit counter SHALL clear on entry to a busy state and increment each busy cycle without ack. At count = TIMEOUT with no ack, the access SHALL be aborted: mem_req=0, done pulse with d_err=1 (data) or if_rdata=0 (fetch), return to IDLE.
REQ-014 Ack and timeout in the same cycle: ack SHALL win, giving a normal completion.
REQ-015 Requests arriving while busy SHALL wait; they are never dropped.
REQ-016 A requester deasserting before done is illegal; behaviour is unspecified.
REQ-017 stall SHALL be combinational: (if_req & ~if_done) | (d_req & ~d_done).
REQ-018 done pulses SHALL never exceed one cycle; if_done and d_done SHALL never be asserted together.

Reset
REQ-019 rst SHALL asynchronously force: state=IDLE, last_grant=IF, counter=0, and all registered outputs (mem_*, if_/d_rdata, if_/d_done, d_err) to 0.
REQ-020 rst mid-access SHALL drop mem_req immediately and produce no done pulse.

Structure
REQ-021 Package dlx_mem_pkg SHALL hold the size encodings, the FSM state encoding and the TIMEOUT default.
REQ-022 Load extension SHALL be a combinational sub-module named load_extend (inputs rdata, size, sign; output data).

Verification
REQ-023 Fetch only, if_addr=0x100, ack on 3rd busy cycle, mem_rdata=0x20010005 -> if_done after 4 busy-related cycles with if_rdata=0x20010005; stall high until done.
REQ-024 if_req and d_req together, load byte signed at 0x203, mem_rdata=0x000000F0 -> data served first with d_rdata=0xFFFFFFF0, then fetch; repeat with both pending -> fetch served first.
REQ-025 Load half at 0x201 -> DERR: d_done=1, d_err=1, no mem_req ever asserted.
REQ-026 Store word at 0x40, no ack -> mem_req high for TIMEOUT cycles, then d_done with d_err=1; a variant acking on the final cycle -> d_err=0.
REQ-027 rst asserted while DBUSY with mem_req=1 -> mem_req=0 within the same cycle, no d_done, state IDLE; the next request completes normally.
